// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encodings as the debug
// unit decodes them, default widths, and a small state decode helper.
package cpu_run_ctrl_pkg;

  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_BRST_W = 16;
  localparam int unsigned DEF_CYC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BURST  = 2'b10,
    ST_BPHALT = 2'b11
  } run_state_e;

  // CPU is stopped in IDLE and BPHALT
  function automatic logic is_halted(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_BPHALT);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw board input plus a one-clk rising-edge pulse.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous switch/button level
//   level    : synchronized level (registered)
//   rise_c   : one-clk pulse on each synchronized 0->1 transition
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_c
);

  logic meta_q;
  logic prev_q;

  // synchronizer chain and edge-history flop
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      level  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= raw;
      level  <= meta_q;
      prev_q <= level;
    end
  end

  assign rise_c = level & ~prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: turns run/step/burst controls into a one-clk CPU clock
// enable, with PC breakpoint halt and status for the debug display.
//   clk, rst          : system clock, synchronous active-high reset
//   run, step, burst  : raw switch / buttons
//   burst_n           : burst length, sampled on the burst edge
//   bp_en, bp_addr    : breakpoint enable and PC
//   pc                : CPU PC, valid the clk after each cpu_ce
//   cpu_ce            : CPU clock enable (registered)
//   halted            : decode of state (IDLE or BPHALT)
//   state             : 00 IDLE, 01 RUN, 10 BURST, 11 BPHALT
//   bp_hit            : sticky breakpoint-taken flag
//   burst_left        : remaining burst cycles
//   cyc_cnt           : cpu_ce pulses since reset
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned BRST_W = DEF_BRST_W,
  parameter int unsigned CYC_W  = DEF_CYC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              burst,
  input  logic [BRST_W-1:0] burst_n,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc,
  output logic              cpu_ce,
  output logic              halted,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [BRST_W-1:0] burst_left,
  output logic [CYC_W-1:0]  cyc_cnt
);

  logic run_meta_q, run_s;
  logic step_lvl, step_p_c;
  logic burst_lvl, burst_p_c;

  run_state_e        state_q, state_n;
  logic              phase_q, phase_n;   // 1 = current cycle is an issue cycle
  logic              skip_q, skip_n;
  logic              bp_hit_q, bp_hit_n;
  logic              ce_n;
  logic [BRST_W-1:0] left_q, left_n;
  logic [CYC_W-1:0]  cyc_q;
  logic              cpu_ce_q;
  logic              bp_match_c;

  // run is a level: synchronizer only
  always_ff @(posedge clk) begin
    if (rst) begin
      run_meta_q <= 1'b0;
      run_s      <= 1'b0;
    end else begin
      run_meta_q <= run;
      run_s      <= run_meta_q;
    end
  end

  btn_sync_edge u_step_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (step),
    .level  (step_lvl),
    .rise_c (step_p_c)
  );

  btn_sync_edge u_burst_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (burst),
    .level  (burst_lvl),
    .rise_c (burst_p_c)
  );

  assign bp_match_c = bp_en && (pc == bp_addr) && !skip_q;

  // Next-state logic. Entries from a stopped state issue at once unless the
  // current cycle is already an issue cycle (trailing step ce); then they
  // start with a gap so no ce is ever doubled.
  always_comb begin
    state_n  = state_q;
    ce_n     = 1'b0;
    phase_n  = 1'b0;
    skip_n   = skip_q;
    bp_hit_n = bp_hit_q;
    left_n   = left_q;

    if (phase_q) skip_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_s) begin
          state_n  = ST_RUN;
          bp_hit_n = 1'b0;
          skip_n   = 1'b1;
          ce_n     = ~phase_q;
        end else if (step_p_c) begin
          bp_hit_n = 1'b0;
          ce_n     = 1'b1;
        end else if (burst_p_c && (burst_n != '0)) begin
          state_n  = ST_BURST;
          left_n   = burst_n;
          bp_hit_n = 1'b0;
          skip_n   = 1'b1;
          ce_n     = ~phase_q;
        end
      end
      ST_RUN: begin
        if (phase_q) begin
          ce_n = 1'b0;
        end else if (!run_s) begin
          state_n = ST_IDLE;
        end else if (bp_match_c) begin
          state_n  = ST_BPHALT;
          bp_hit_n = 1'b1;
        end else begin
          ce_n = 1'b1;
        end
      end
      ST_BURST: begin
        if (phase_q) begin
          left_n = left_q - BRST_W'(1);
        end else if (bp_match_c) begin
          state_n  = ST_BPHALT;
          bp_hit_n = 1'b1;
        end else if (left_q == '0) begin
          state_n = ST_IDLE;
        end else begin
          ce_n = 1'b1;
        end
      end
      ST_BPHALT: begin
        if (step_p_c) begin
          state_n  = ST_IDLE;
          bp_hit_n = 1'b0;
          ce_n     = 1'b1;
        end else if (burst_p_c && (burst_n != '0)) begin
          state_n  = ST_BURST;
          left_n   = burst_n;
          bp_hit_n = 1'b0;
          skip_n   = 1'b1;
          ce_n     = ~phase_q;
        end else if (!run_s) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    phase_n = ce_n;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= 1'b0;
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      left_q   <= '0;
      cpu_ce_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_n;
      phase_q  <= phase_n;
      skip_q   <= skip_n;
      bp_hit_q <= bp_hit_n;
      left_q   <= left_n;
      cpu_ce_q <= ce_n;
      if (cpu_ce_q) cyc_q <= cyc_q + CYC_W'(1);
    end
  end

  assign cpu_ce     = cpu_ce_q;
  assign state      = state_q;
  assign halted     = is_halted(state_q);
  assign bp_hit     = bp_hit_q;
  assign burst_left = left_q;
  assign cyc_cnt    = cyc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a PC model advances by 4 on every
// cpu_ce, a monitor counts ce pulses and back-to-back violations, and each
// scenario task checks the DUT against expectations derived from the rules.
module tb_cpu_run_ctrl;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned BRST_W = 16;
  localparam int unsigned CYC_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              run, step, burst, bp_en;
  logic [BRST_W-1:0] burst_n;
  logic [PC_W-1:0]   bp_addr;
  logic [PC_W-1:0]   pc;
  logic              cpu_ce, halted, bp_hit;
  logic [1:0]        state;
  logic [BRST_W-1:0] burst_left;
  logic [CYC_W-1:0]  cyc_cnt;

  int nchk = 0;
  int npass = 0;
  int ce_obs = 0;
  int dbl = 0;
  bit prev_ce = 1'b0;
  int exp_cyc = 0;

  cpu_run_ctrl #(.PC_W(PC_W), .BRST_W(BRST_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .burst(burst),
    .burst_n(burst_n), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .halted(halted), .state(state), .bp_hit(bp_hit),
    .burst_left(burst_left), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  // CPU model: advances 4 bytes per enabled clock
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  // ce pulse monitor
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      ce_obs++;
      if (prev_ce) dbl++;
    end
    prev_ce = (cpu_ce === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; burst = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    exp_cyc = 0;
  endtask

  task automatic test_reset();
    int c0;
    rst = 1'b1; run = 1'b0; step = 1'b0; burst = 1'b0;
    bp_en = 1'b0; bp_addr = '0; burst_n = '0;
    tick(3);
    nchk++; if (cpu_ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", cpu_ce); else npass++;
    nchk++; if (state !== 2'b00) $display("FAIL reset_state: got %b want 00", state); else npass++;
    nchk++; if (halted !== 1'b1) $display("FAIL reset_halted: got %b want 1", halted); else npass++;
    nchk++; if (bp_hit !== 1'b0) $display("FAIL reset_bp_hit: got %b want 0", bp_hit); else npass++;
    nchk++; if (burst_left !== '0) $display("FAIL reset_burst_left: got %0d want 0", burst_left); else npass++;
    nchk++; if (cyc_cnt !== '0) $display("FAIL reset_cyc_cnt: got %0d want 0", cyc_cnt); else npass++;
    rst = 1'b0;
    c0 = ce_obs;
    tick(20);
    nchk++; if (ce_obs != c0) $display("FAIL idle_no_ce: got %0d pulses want 0", ce_obs - c0); else npass++;
    nchk++; if (state !== 2'b00) $display("FAIL idle_state: got %b want 00", state); else npass++;
    nchk++; if (cyc_cnt !== '0) $display("FAIL idle_cyc_cnt: got %0d want 0", cyc_cnt); else npass++;
    exp_cyc = 0;
  endtask

  task automatic test_step();
    int c0;
    c0 = ce_obs;
    step = 1'b1;
    tick(2);
    nchk++; if (cpu_ce !== 1'b0) $display("FAIL step_early: got %b want 0", cpu_ce); else npass++;
    tick(1);
    nchk++; if (cpu_ce !== 1'b1) $display("FAIL step_ce: got %b want 1", cpu_ce); else npass++;
    step = 1'b0;
    tick(1);
    nchk++; if (cpu_ce !== 1'b0) $display("FAIL step_single: got %b want 0", cpu_ce); else npass++;
    exp_cyc++;
    nchk++; if (cyc_cnt !== CYC_W'(exp_cyc)) $display("FAIL step_cyc1: got %0d want %0d", cyc_cnt, exp_cyc); else npass++;
    for (int i = 0; i < 10; i++) begin
      step = 1'b1;
      tick(int'($urandom_range(1, 3)));
      step = 1'b0;
      tick(int'($urandom_range(2, 4)));
      exp_cyc++;
    end
    tick(5);
    nchk++; if (ce_obs - c0 != 11) $display("FAIL step_pulses: got %0d want 11", ce_obs - c0); else npass++;
    nchk++; if (cyc_cnt !== CYC_W'(exp_cyc)) $display("FAIL step_cyc10: got %0d want %0d", cyc_cnt, exp_cyc); else npass++;
    nchk++; if (state !== 2'b00) $display("FAIL step_state: got %b want 00", state); else npass++;
  endtask

  task automatic test_run(input int hold);
    int c0, n, d0;
    c0 = ce_obs; d0 = dbl;
    run = 1'b1;
    tick(10);
    nchk++; if (state !== 2'b01) $display("FAIL run_state: got %b want 01", state); else npass++;
    nchk++; if (halted !== 1'b0) $display("FAIL run_halted: got %b want 0", halted); else npass++;
    tick(hold - 10);
    run = 1'b0;
    tick(8);
    n = ce_obs - c0;
    nchk++; if (dbl != d0) $display("FAIL run_back_to_back: got %0d doubles want 0", dbl - d0); else npass++;
    nchk++;
    if (n < hold / 2 - 1 || n > hold / 2 + 1)
      $display("FAIL run_count: got %0d ce want %0d..%0d for hold %0d", n, hold / 2 - 1, hold / 2 + 1, hold);
    else npass++;
    nchk++; if (state !== 2'b00) $display("FAIL run_stop_state: got %b want 00", state); else npass++;
    nchk++; if (cpu_ce !== 1'b0) $display("FAIL run_stop_ce: got %b want 0", cpu_ce); else npass++;
    exp_cyc += n;
    nchk++; if (cyc_cnt !== CYC_W'(exp_cyc)) $display("FAIL run_cyc: got %0d want %0d", cyc_cnt, exp_cyc); else npass++;
  endtask

  task automatic test_burst(input int n);
    int c0, first, last, prevl, bad, cur;
    bit seen, done, busy_ok;
    c0 = ce_obs; first = -1; last = -1; prevl = -1; bad = 0;
    seen = 1'b0; done = 1'b0; busy_ok = 1'b1;
    burst_n = BRST_W'(n);
    burst = 1'b1;
    tick(1);
    burst = 1'b0;
    if (n == 0) begin
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (state !== 2'b00) busy_ok = 1'b0;
      end
      nchk++; if (ce_obs != c0) $display("FAIL burst0_ce: got %0d want 0", ce_obs - c0); else npass++;
      nchk++; if (!busy_ok) $display("FAIL burst0_state: got non-idle want 00"); else npass++;
    end else begin
      for (int i = 0; i < 4 * n + 20 && !done; i++) begin
        tick(1);
        if (state === 2'b10) begin
          cur = int'(burst_left);
          if (!seen) first = cur;
          else if (cur != prevl && cur != prevl - 1) bad++;
          if (halted !== 1'b0) busy_ok = 1'b0;
          seen = 1'b1; prevl = cur; last = cur;
        end else if (seen) done = 1'b1;
      end
      burst_n = BRST_W'($urandom);
      nchk++; if (!done) $display("FAIL burst_timeout: got no return to idle want idle within %0d clks", 4 * n + 20); else npass++;
      nchk++; if (ce_obs - c0 != n) $display("FAIL burst_count: got %0d ce want %0d", ce_obs - c0, n); else npass++;
      nchk++; if (first != n) $display("FAIL burst_left_first: got %0d want %0d", first, n); else npass++;
      nchk++; if (last != 0) $display("FAIL burst_left_last: got %0d want 0", last); else npass++;
      nchk++; if (bad != 0) $display("FAIL burst_left_steps: got %0d bad steps want 0", bad); else npass++;
      nchk++; if (!busy_ok) $display("FAIL burst_halted: got 1 want 0 during burst"); else npass++;
      nchk++; if (state !== 2'b00) $display("FAIL burst_end_state: got %b want 00", state); else npass++;
      exp_cyc += n;
      nchk++; if (cyc_cnt !== CYC_W'(exp_cyc)) $display("FAIL burst_cyc: got %0d want %0d", cyc_cnt, exp_cyc); else npass++;
    end
  endtask

  task automatic test_breakpoint_run(input int k);
    int c0;
    bit found;
    do_reset();
    c0 = ce_obs; found = 1'b0;
    bp_en = 1'b1;
    bp_addr = PC_W'(4 * k);
    run = 1'b1;
    for (int i = 0; i < 8 * k + 40 && !found; i++) begin
      tick(1);
      if (state === 2'b11) found = 1'b1;
    end
    nchk++; if (!found) $display("FAIL bp_timeout: got state %b want 11", state); else npass++;
    nchk++; if (pc !== bp_addr) $display("FAIL bp_pc: got %h want %h", pc, bp_addr); else npass++;
    nchk++; if (ce_obs - c0 != k) $display("FAIL bp_count: got %0d ce want %0d", ce_obs - c0, k); else npass++;
    nchk++; if (bp_hit !== 1'b1) $display("FAIL bp_hit_set: got %b want 1", bp_hit); else npass++;
    tick(10);
    nchk++; if (state !== 2'b11 || halted !== 1'b1) $display("FAIL bp_hold: got state %b halted %b want 11/1", state, halted); else npass++;
    nchk++; if (ce_obs - c0 != k) $display("FAIL bp_hold_ce: got %0d ce want %0d", ce_obs - c0, k); else npass++;
    run = 1'b0;
    tick(6);
    nchk++; if (state !== 2'b00 || bp_hit !== 1'b1) $display("FAIL bp_release: got state %b bp_hit %b want 00/1", state, bp_hit); else npass++;
    run = 1'b1;
    tick(6);
    nchk++; if (state !== 2'b01 || bp_hit !== 1'b0) $display("FAIL bp_resume: got state %b bp_hit %b want 01/0", state, bp_hit); else npass++;
    tick(20);
    nchk++; if (state !== 2'b01) $display("FAIL bp_no_retrap: got state %b want 01", state); else npass++;
    nchk++; if (pc <= bp_addr) $display("FAIL bp_advance: got pc %h want above %h", pc, bp_addr); else npass++;
    run = 1'b0;
    tick(8);
    nchk++; if (cyc_cnt !== CYC_W'(ce_obs - c0)) $display("FAIL bp_cyc: got %0d want %0d", cyc_cnt, ce_obs - c0); else npass++;
    exp_cyc = ce_obs - c0;
    bp_en = 1'b0;
  endtask

  task automatic test_breakpoint_burst(input int k, input int n);
    int c0;
    bit found;
    do_reset();
    c0 = ce_obs; found = 1'b0;
    bp_en = 1'b1;
    bp_addr = PC_W'(4 * k);
    burst_n = BRST_W'(n);
    burst = 1'b1;
    tick(1);
    burst = 1'b0;
    for (int i = 0; i < 4 * n + 20 && !found; i++) begin
      tick(1);
      if (bp_hit === 1'b1) found = 1'b1;
    end
    tick(4);
    nchk++; if (!found) $display("FAIL bpb_timeout: got bp_hit 0 want 1"); else npass++;
    nchk++; if (ce_obs - c0 != k) $display("FAIL bpb_count: got %0d ce want %0d", ce_obs - c0, k); else npass++;
    nchk++; if (burst_left !== BRST_W'(n - k)) $display("FAIL bpb_left_held: got %0d want %0d", burst_left, n - k); else npass++;
    nchk++; if (state !== 2'b00 || bp_hit !== 1'b1) $display("FAIL bpb_idle: got state %b bp_hit %b want 00/1", state, bp_hit); else npass++;
    exp_cyc = k;
    bp_en = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int c0;
    bit reached;
    c0 = ce_obs; reached = 1'b0;
    burst_n = BRST_W'(100);
    burst = 1'b1;
    tick(1);
    burst = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      tick(1);
      if (ce_obs - c0 >= 10) reached = 1'b1;
    end
    nchk++; if (!reached) $display("FAIL rstmid_timeout: got %0d ce want 10", ce_obs - c0); else npass++;
    rst = 1'b1;
    tick(1);
    nchk++; if (cpu_ce !== 1'b0) $display("FAIL rstmid_ce: got %b want 0", cpu_ce); else npass++;
    nchk++; if (burst_left !== '0) $display("FAIL rstmid_left: got %0d want 0", burst_left); else npass++;
    nchk++; if (cyc_cnt !== '0) $display("FAIL rstmid_cyc: got %0d want 0", cyc_cnt); else npass++;
    nchk++; if (state !== 2'b00) $display("FAIL rstmid_state: got %b want 00", state); else npass++;
    rst = 1'b0;
    exp_cyc = 0;
  endtask

  initial begin
    int k;
    test_reset();
    test_step();
    test_run(40);
    test_run(int'($urandom_range(20, 60)));
    test_burst(5);
    test_burst(int'($urandom_range(1, 30)));
    test_burst(0);
    test_breakpoint_run(3);
    test_breakpoint_run(int'($urandom_range(1, 12)));
    k = int'($urandom_range(1, 10));
    test_breakpoint_burst(k, k + int'($urandom_range(1, 20)));
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
